// File: rtl/serial_shift_unit_if.sv
// rtl/serial_shift_unit_if.sv - request/response bundle for the serial shift unit
interface serial_shift_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] operand;
    logic [31:0]      shamt_ext;
    logic [WIDTH-1:0] result;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output start, op, operand, shamt_ext,
        input  result, busy, done, err
    );

    modport slave (
        input  start, op, operand, shamt_ext,
        output result, busy, done, err
    );
endinterface

// File: rtl/serial_shift_unit.sv
// rtl/serial_shift_unit.sv - one-bit-per-clock sll/srl/sra unit; SERIAL_SHIFT_ROTATE_EN adds op=11 rotate right
module serial_shift_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_shift_unit_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state;
    logic [WIDTH-1:0]   work;
    logic [WIDTH-1:0]   shifted;
    logic [1:0]         op_q;
    logic [SHAMT_W-1:0] cnt;
    logic [WIDTH-1:0]   result_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;
    logic [SHAMT_W-1:0] n_in;
    logic               upper_nz;
    logic               illegal_op;

    assign n_in     = bus.shamt_ext[SHAMT_W-1:0];
    assign upper_nz = |bus.shamt_ext[31:SHAMT_W];
`ifdef SERIAL_SHIFT_ROTATE_EN
    assign illegal_op = 1'b0;
`else
    assign illegal_op = (bus.op == 2'b11);
`endif

    always_comb begin
        shifted = work;
        case (op_q)
            2'b00:   shifted = {work[WIDTH-2:0], 1'b0};
            2'b01:   shifted = {1'b0, work[WIDTH-1:1]};
            2'b10:   shifted = {work[WIDTH-1], work[WIDTH-1:1]};
            default: begin
`ifdef SERIAL_SHIFT_ROTATE_EN
                shifted = {work[0], work[WIDTH-1:1]};
`else
                shifted = work;
`endif
            end
        endcase
    end

    // cnt holds the shifts still to perform; the edge that consumes the last one enters DONE
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            work     <= '0;
            op_q     <= '0;
            cnt      <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        work   <= bus.operand;
                        op_q   <= bus.op;
                        cnt    <= n_in;
                        err_q  <= upper_nz | illegal_op;
                        busy_q <= 1'b1;
                        if (n_in == '0) begin
                            result_q <= bus.operand;
                            done_q   <= 1'b1;
                            state    <= DONE;
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    work <= shifted;
                    cnt  <= cnt - 1'b1;
                    if (cnt == SHAMT_W'(1)) begin
                        result_q <= shifted;
                        done_q   <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.result = result_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.err    = err_q;
endmodule

// File: tb/tb_serial_shift_unit.sv
// tb/tb_serial_shift_unit.sv - scoreboard bench for serial_shift_unit against an arithmetic reference model
module tb_serial_shift_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    typedef struct {
        logic [31:0] res;
        logic        err;
        int          c0;
        int          n;
    } exp_t;

    exp_t        q[$];
    logic [31:0] last_res = '0;
    logic        last_err = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_shift_unit_if #(.WIDTH(32)) bus ();

    serial_shift_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] s);
        int n;
        n = int'(s % 32);
        case (o)
            2'd0:    return a << n;
            2'd1:    return a >> n;
            2'd2:    return $unsigned($signed(a) >>> n);
`ifdef SERIAL_SHIFT_ROTATE_EN
            default: return (n == 0) ? a : ((a >> n) | (a << (32 - n)));
`else
            default: return a;
`endif
        endcase
    endfunction

    function automatic logic model_err(input logic [1:0] o, input logic [31:0] s);
`ifdef SERIAL_SHIFT_ROTATE_EN
        return (s >= 32);
`else
        return (s >= 32) || (o == 2'd3);
`endif
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && bus.done) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 expected no pending op");
            end else begin
                e = q.pop_front();
                check("result", bus.result, e.res);
                check("err", 32'(bus.err), 32'(e.err));
                check("latency", 32'(cyc - e.c0), 32'(e.n + 1));
                check("busy_at_done", 32'(bus.busy), 32'd1);
            end
        end
    end

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] s, input bit pulse);
        exp_t e;
        int   busy_cnt;
        int   waited;
        check("hold_result", bus.result, last_res);
        check("hold_err", 32'(bus.err), 32'(last_err));
        bus.op        = o;
        bus.operand   = a;
        bus.shamt_ext = s;
        bus.start     = 1'b1;
        e.res = model(o, a, s);
        e.err = model_err(o, s);
        e.c0  = cyc;
        e.n   = int'(s % 32);
        q.push_back(e);
        last_res = e.res;
        last_err = e.err;
        @(negedge clk);
        bus.start = 1'b0;
        busy_cnt  = 0;
        waited    = 0;
        while (1) begin
            if (bus.busy) busy_cnt++;
            if (bus.done) break;
            if (waited > 40) begin
                check("done_timeout", 32'(waited), 32'(e.n + 1));
                break;
            end
            bus.op        = 2'($urandom);
            bus.operand   = $urandom;
            bus.shamt_ext = $urandom;
            bus.start     = pulse ? 1'($urandom) : 1'b0;
            @(negedge clk);
            waited++;
        end
        bus.start = 1'b0;
        check("busy_cycles", 32'(busy_cnt), 32'(e.n + 1));
        @(negedge clk);
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("idle_done", 32'(bus.done), 32'd0);
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.op        = '0;
        bus.operand   = '0;
        bus.shamt_ext = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_result", bus.result, 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // accept a 20-bit shift, then reset on the 5th edge: no completion may follow
        bus.op = 2'd0; bus.operand = 32'hDEADBEEF; bus.shamt_ext = 32'd20; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_result", bus.result, 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_err", 32'(bus.err), 32'd0);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);

        run_op(2'd1, 32'h80000000, 32'd4, 1'b0);
        run_op(2'd2, 32'h80000000, 32'd4, 1'b0);
        run_op(2'd0, 32'h12345678, 32'd0, 1'b0);
        run_op(2'd0, 32'h00000001, 32'd31, 1'b1);
        run_op(2'd0, 32'h00000003, 32'h00000021, 1'b0);
        run_op(2'd3, 32'h00000001, 32'd1, 1'b0);
        run_op(2'd2, 32'h7FFFFFFF, 32'd31, 1'b1);

        for (int i = 0; i < 30; i++) begin
            logic [31:0] s;
            if ($urandom_range(0, 3) == 0) s = $urandom;
            else s = 32'($urandom_range(0, 31));
            run_op(2'($urandom_range(0, 3)), $urandom, s, 1'($urandom));
        end

        repeat (3) @(negedge clk);
        check("queue_empty", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
